// File: rtl/hack_rom_loader.sv
// Loads a framed big-endian program image into the Hack instruction ROM.
// The CPU is held in reset until the image's XOR checksum has been verified.
module hack_rom_loader #(
    parameter int          ADDR_W    = 15,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              restart_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [15:0]       rom_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              error_o
);

    // state  | meaning
    // SYNC   | hunting for SYNC_BYTE, address and checksum cleared
    // LEN_H  | expecting length[15:8]
    // LEN_L  | expecting length[7:0], range-checked against capacity
    // D_HI   | expecting high byte of the next word
    // D_LO   | expecting low byte; word written the following cycle
    // CHK    | expecting checksum byte
    // DONE   | image loaded and verified, CPU released
    // ERR    | overflow or checksum mismatch, CPU held
    typedef enum logic [2:0] {
        S_SYNC, S_LEN_H, S_LEN_L, S_D_HI, S_D_LO, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0]       CAPACITY = 17'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t             state, next_state;
    logic               ready_q;
    logic               xfer;
    logic [7:0]         len_hi;
    logic [7:0]         hi_byte;
    logic [7:0]         csum;
    logic [15:0]        remain;
    logic [ADDR_W-1:0]  addr;
    logic [15:0]        len_full;

    logic               take_len_h, take_len_l, take_hi, take_lo;
    logic               clear_ctx;
    logic               ready_d, cpu_rst_d, done_d, error_d;

    // Registered readiness, gated by restart so a concurrent byte is refused.
    assign rx_ready_o = ready_q & ~restart_i;
    assign xfer       = rx_valid_i & rx_ready_o;
    assign len_full   = {len_hi, rx_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_SYNC;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (restart_i) begin
            next_state = S_SYNC;
        end else if (xfer) begin
            unique case (state)
                S_SYNC:  if (rx_data_i == SYNC_BYTE) next_state = S_LEN_H;
                S_LEN_H: next_state = S_LEN_L;
                S_LEN_L: begin
                    if ({1'b0, len_full} > CAPACITY) next_state = S_ERR;
                    else if (len_full == 16'd0)      next_state = S_CHK;
                    else                             next_state = S_D_HI;
                end
                S_D_HI:  next_state = S_D_LO;
                S_D_LO:  next_state = (remain == 16'd1) ? S_CHK : S_D_HI;
                S_CHK:   next_state = (rx_data_i == csum) ? S_DONE : S_ERR;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        take_len_h = xfer && (state == S_LEN_H);
        take_len_l = xfer && (state == S_LEN_L);
        take_hi    = xfer && (state == S_D_HI);
        take_lo    = xfer && (state == S_D_LO);
        clear_ctx  = (next_state == S_SYNC);
        ready_d    = (next_state != S_DONE) && (next_state != S_ERR);
        cpu_rst_d  = (next_state != S_DONE);
        done_d     = (next_state == S_DONE);
        error_d    = (next_state == S_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q    <= 1'b1;
            rom_we_o   <= 1'b0;
            rom_addr_o <= '0;
            rom_data_o <= '0;
            cpu_rst_o  <= 1'b1;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            len_hi     <= '0;
            hi_byte    <= '0;
            csum       <= '0;
            remain     <= '0;
            addr       <= '0;
        end else begin
            ready_q   <= ready_d;
            cpu_rst_o <= cpu_rst_d;
            done_o    <= done_d;
            error_o   <= error_d;
            rom_we_o  <= take_lo;
            if (take_len_h) len_hi <= rx_data_i;
            if (take_len_l) remain <= len_full;
            if (take_hi) begin
                hi_byte <= rx_data_i;
                csum    <= csum ^ rx_data_i;
            end
            if (take_lo) begin
                rom_addr_o <= addr;
                rom_data_o <= {hi_byte, rx_data_i};
                addr       <= addr + ADDR_ONE;
                remain     <= remain - 16'd1;
                csum       <= csum ^ rx_data_i;
            end
            // Never coincides with take_lo: restart blocks the handshake.
            if (clear_ctx) begin
                csum <= '0;
                addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader (ADDR_W=4, so capacity is 16 words).
// Expected ROM writes are queued as bytes are sent and compared by a write monitor.
module tb_hack_rom_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          restart = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          cpu_rst;
    logic          done;
    logic          error;

    hack_rom_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .restart_i  (restart),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .rom_we_o   (rom_we),
        .rom_addr_o (rom_addr),
        .rom_data_o (rom_data),
        .cpu_rst_o  (cpu_rst),
        .done_o     (done),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] tx_q[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write scoreboard: each strobe must match the next queued write and its cycle.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%0h data=%04h at cyc %0d, required no write",
                         rom_addr, rom_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (rom_addr !== mon_e.addr || rom_data !== mon_e.data || cyc !== mon_e.cyc)
                    $display("FAIL rom_write: got addr=%0h data=%04h cyc=%0d, required addr=%0h data=%04h cyc=%0d",
                             rom_addr, rom_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                else
                    n_pass++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        #1;
        while (rx_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w == 8) begin
            n_total++;
            $display("FAIL handshake: rx_ready=%b for byte %02h, required 1 within 8 cycles", rx_ready, b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends tx_q; the frame starts at index off. Queues every write the frame implies.
    task automatic send_frame(input int off, input int gap_max);
        int len;
        int j;
        wr_t e;
        len = -1;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i > 0 && gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
            send_byte(tx_q[i]);
            j = i - off;
            if (j == 2) len = {tx_q[i-1], tx_q[i]};
            if (j >= 3 && len > 0 && len <= (1 << AW) && j < 3 + 2 * len && ((j - 3) % 2) == 1) begin
                e.addr = AW'((j - 3) / 2);
                e.data = {tx_q[i-1], tx_q[i]};
                e.cyc  = cyc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic load_nominal();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h07, 8'hEC, 8'h10, 8'hFB};
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        @(negedge clk);
        n_total++;
        if ({done, error, cpu_rst, rx_ready} !== 4'b0011)
            $display("FAIL restart_state: {done,error,cpu_rst,ready}=%b, required 0011",
                     {done, error, cpu_rst, rx_ready});
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rx_ready, rom_we, cpu_rst, done, error} !== 5'b10100)
            $display("FAIL reset_flags: {ready,we,cpu_rst,done,error}=%b, required 10100",
                     {rx_ready, rom_we, cpu_rst, done, error});
        else n_pass++;
        n_total++;
        if (rom_addr !== '0 || rom_data !== 16'h0000)
            $display("FAIL reset_bus: addr=%0h data=%04h, required 0/0000", rom_addr, rom_data);
        else n_pass++;
    endtask

    task automatic test_nominal(input string name, input int off, input int gap_max);
        send_frame(off, gap_max);
        @(negedge clk);
        n_total++;
        if ({done, error, cpu_rst, rx_ready} !== 4'b1000)
            $display("FAIL %s_done: {done,error,cpu_rst,ready}=%b, required 1000", name,
                     {done, error, cpu_rst, rx_ready});
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0 || rom_addr !== 4'd1 || rom_data !== 16'hEC10)
            $display("FAIL %s_writes: pending=%0d addr=%0h data=%04h, required 0 pending, hold 1/EC10",
                     name, exp_q.size(), rom_addr, rom_data);
        else n_pass++;
        do_restart();
    endtask

    task automatic test_back_to_back();
        load_nominal();
        test_nominal("back_to_back", 0, 0);
    endtask

    task automatic test_garbage();
        load_nominal();
        tx_q.push_front(8'h5A);
        tx_q.push_front(8'hFF);
        tx_q.push_front(8'h00);
        test_nominal("garbage", 3, 0);
    endtask

    task automatic test_gapped();
        for (int r = 0; r < 3; r++) begin
            load_nominal();
            test_nominal("gapped", 0, 3);
        end
    endtask

    task automatic test_bad_checksum();
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
        send_frame(0, 0);
        @(negedge clk);
        n_total++;
        if ({done, error, cpu_rst, rx_ready} !== 4'b0110 || exp_q.size() != 0)
            $display("FAIL bad_chk: {done,error,cpu_rst,ready}=%b pending=%0d, required 0110 and 0",
                     {done, error, cpu_rst, rx_ready}, exp_q.size());
        else n_pass++;
        do_restart();
    endtask

    task automatic test_zero_len();
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0, 0);
        @(negedge clk);
        n_total++;
        if ({done, error, cpu_rst, rx_ready} !== 4'b1000)
            $display("FAIL zero_len: {done,error,cpu_rst,ready}=%b, required 1000",
                     {done, error, cpu_rst, rx_ready});
        else n_pass++;
        do_restart();
    endtask

    task automatic test_overflow();
        tx_q = '{8'hA5, 8'h00, 8'h11};
        send_frame(0, 0);
        @(negedge clk);
        n_total++;
        if ({done, error, cpu_rst, rx_ready} !== 4'b0110)
            $display("FAIL overflow: {done,error,cpu_rst,ready}=%b, required 0110",
                     {done, error, cpu_rst, rx_ready});
        else n_pass++;
        do_restart();
    endtask

    task automatic test_full_capacity();
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        tx_q = '{8'hA5, 8'h00, 8'h10};
        for (int k = 0; k < 32; k++) begin
            b = 8'($urandom_range(0, 255));
            x = x ^ b;
            tx_q.push_back(b);
        end
        tx_q.push_back(x);
        send_frame(0, 0);
        @(negedge clk);
        n_total++;
        if ({done, error, cpu_rst} !== 3'b100 || exp_q.size() != 0 || rom_addr !== 4'hF)
            $display("FAIL full_capacity: {done,error,cpu_rst}=%b pending=%0d addr=%0h, required 100, 0, F",
                     {done, error, cpu_rst}, exp_q.size(), rom_addr);
        else n_pass++;
        do_restart();
    endtask

    task automatic test_abort();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h07};
        send_frame(0, 0);
        @(negedge clk);
        rx_data  = 8'hEC;
        rx_valid = 1'b1;
        restart  = 1'b1;
        #1;
        n_total++;
        if (rx_ready !== 1'b0)
            $display("FAIL abort_ready: rx_ready=%b during restart, required 0", rx_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        restart  = 1'b0;
        load_nominal();
        test_nominal("abort", 0, 0);
    endtask

    task automatic test_reset_mid();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h07};
        send_frame(0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rx_ready, rom_we, cpu_rst, done, error} !== 5'b10100 || rom_addr !== '0 || rom_data !== 16'h0000)
            $display("FAIL reset_mid: {ready,we,cpu_rst,done,error}=%b addr=%0h data=%04h, required 10100 0 0000",
                     {rx_ready, rom_we, cpu_rst, done, error}, rom_addr, rom_data);
        else n_pass++;
        load_nominal();
        test_nominal("after_reset", 0, 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_garbage();
        test_bad_checksum();
        test_zero_len();
        test_overflow();
        test_full_capacity();
        test_gapped();
        test_abort();
        test_reset_mid();
        repeat (4) @(negedge clk);
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL leftover_writes: pending=%0d, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Byte-stream writer for the Hack instruction ROM: the producer end of the instruction path the controller decodes. It receives a framed program image over a valid/ready byte interface, packs big-endian 16-bit instruction words, and writes them to consecutive ROM addresses from 0. It verifies an XOR checksum and holds the CPU in reset until a load completes successfully. It sits between the host link (UART receiver or testbench) and the ROM write port.

## Interface

Parameters:
- ADDR_W, 15, ROM address width; capacity 2^ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- restart_i  input  1  abort/re-arm pulse; returns the block to SYNC.
- rx_data_i  input  8  incoming byte.
- rx_valid_i  input  1  rx_data_i valid.
- rx_ready_o  output  1  block accepts a byte this cycle.
- rom_we_o  output  1  one-cycle ROM write strobe.
- rom_addr_o  output  ADDR_W  ROM write address.
- rom_data_o  output  16  ROM write data (instruction word).
- cpu_rst_o  output  1  CPU hold-in-reset; high unless DONE.
- done_o  output  1  load finished, checksum good.
- error_o  output  1  load failed (length overflow or checksum mismatch).

## Operation

- Frame: SYNC_BYTE, LEN_HI, LEN_LO, then 2×LEN data bytes (word high byte first), then CHK byte. LEN counts 16-bit words. CHK is the XOR of all data bytes only (0x00 when LEN=0).
- A byte is transferred on a rising edge where rx_valid_i & rx_ready_o. No other byte is consumed.
- States:
  - SYNC: discard non-SYNC bytes. SYNC_BYTE goes to LEN_H.
  - LEN_H: latch length[15:8] and go to LEN_L.
  - LEN_L: latch length[7:0].
    - If the length exceeds 2^ADDR_W, go to ERR.
    - Else if the length is 0, go to CHK.
    - Else go to D_HI.
  - D_HI: latch high byte, XOR it into the checksum, go to D_LO.
  - D_LO: form the word, XOR the byte into the checksum, issue the write, and decrement the remaining count. Go to CHK if the count reaches 0, else to D_HI.
  - CHK: compare the byte with the accumulated XOR. Equal goes to DONE, else to ERR.
  - DONE and ERR: terminal. Leave only on restart_i or rst_i.
- The checksum accumulator and word address are cleared on entry to SYNC.
- rx_ready_o is 1 in SYNC through CHK and 0 in DONE and ERR.
- Write: the word address starts at 0 and increments by 1 after each write. It never wraps, because lengths above capacity are rejected in LEN_L.
- restart_i: from any state, next state is SYNC. Address and checksum are cleared. cpu_rst_o, done_o and error_o all return to their reset values. Words already written are not erased.
- Priority: rst_i > restart_i > byte handshake. A byte presented in the same cycle as restart_i is dropped, and rx_ready_o is forced to 0 that cycle.

## Timing

- Reset values:
  - rx_ready_o=1, state SYNC.
  - rom_we_o=0, rom_addr_o=0, rom_data_o=0.
  - cpu_rst_o=1, done_o=0, error_o=0.
- All outputs are registered.
- Throughput is one byte per cycle with rx_valid_i held high, and the block never stalls mid-frame.
- Write latency: the cycle after the D_LO byte is accepted, rom_we_o=1 for exactly one cycle. In that cycle rom_addr_o is the word index and rom_data_o is {hi,lo}.
- rom_addr_o and rom_data_o hold their last values when rom_we_o=0.
- Completion: the cycle after the CHK byte is accepted, done_o=1 and cpu_rst_o=0 (good checksum), or error_o=1 with cpu_rst_o held at 1 (bad checksum).
- Length overflow asserts error_o the cycle after LEN_L is accepted.
- The last write strobe precedes done_o by at least one cycle.
- restart_i takes effect on the next edge: state SYNC, cpu_rst_o=1, done_o=0, error_o=0, rx_ready_o=1.

## Test plan

- Nominal load, back-to-back:
  - Stimulus: A5 00 02 00 07 EC 10 FB.
  - Required: writes (0,0x0007) then (1,0xEC10), one strobe each.
  - Then done_o=1, cpu_rst_o=0, error_o=0, rx_ready_o=0.
- Garbage before sync:
  - Stimulus: 00 FF 5A, then the nominal frame.
  - Required: no writes during garbage; same results as the nominal load.
- Bad checksum:
  - Stimulus: A5 00 01 12 34 00.
  - Required: one write (0,0x1234), then error_o=1, done_o=0, cpu_rst_o=1.
- Zero length and overflow, each followed by restart_i:
  - Stimulus A5 00 00 00 gives done_o=1 with no writes.
  - With ADDR_W=4, stimulus A5 00 11 gives error_o=1 with no writes.
- Gapped valid:
  - Stimulus: the nominal frame with rx_valid_i low 0–3 random cycles between bytes.
  - Required: identical write sequence and completion to the nominal load.
- Mid-load abort and reset:
  - Stimulus: restart_i after A5 00 02 00 07 (same cycle as the next byte), then the nominal frame.
  - Required: the concurrent byte is dropped; writes restart at addr 0; done_o=1.
  - Stimulus: rst_i mid-frame.
  - Required: every output returns to its reset value on the next edge.
